// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter sitting beside data memory on the store path.
// Word offsets from BASE_ADDR: 0 TXDATA, 1 STATUS, 2 BAUDDIV, 3 CTRL.
// Written bytes queue in a small FIFO; the FSM pops one per frame and serialises it
// LSB first. tx is registered from the FSM state, so the line lags the state by one cycle.
module mmio_uart_tx #(
  parameter int                    ADDR_WIDTH  = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 12'hF00,
  parameter int                    FIFO_DEPTH  = 8,
  parameter int                    DEFAULT_DIV = 868
) (
  input  logic                  sysclk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           w_data,
  input  logic [3:0]            byte_w_en,
  input  logic                  r_en,
  output logic [31:0]           r_data,
  output logic                  tx,
  output logic                  irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------- decode
  logic [ADDR_WIDTH-1:0] offset;
  logic                  in_range;
  logic [1:0]            reg_sel;
  logic                  wr_any;
  logic                  push_req;
  logic                  ovf_clr;
  logic                  div_wr;
  logic                  ctrl_wr;

  // Addresses below BASE_ADDR wrap to a large offset and fall out of range.
  assign offset   = addr - BASE_ADDR;
  assign in_range = (offset < ADDR_WIDTH'(4));
  assign reg_sel  = offset[1:0];
  assign wr_any   = in_range && (byte_w_en != 4'b0000);
  assign push_req = wr_any && (reg_sel == 2'd0) && byte_w_en[0];
  assign ovf_clr  = wr_any && (reg_sel == 2'd1) && byte_w_en[0] && w_data[3];
  assign div_wr   = wr_any && (reg_sel == 2'd2) && (byte_w_en[1:0] != 2'b00);
  assign ctrl_wr  = wr_any && (reg_sel == 2'd3) && byte_w_en[0];

  // Only the low half of the store word ever lands in a register.
  logic unused_w_data;
  assign unused_w_data = ^w_data[31:16];

  // ---------------------------------------------------------------- registers
  logic [15:0] div_reg;
  logic        enable_reg;
  logic        irq_en_reg;
  logic        ovf_reg;
  logic [15:0] div_merged;
  logic [15:0] div_next;

  // Byte-lane merge of a BAUDDIV write; lanes not enabled keep their old value.
  for (genvar gi = 0; gi < 2; gi++) begin : g_div_lane
    assign div_merged[gi*8 +: 8] = byte_w_en[gi] ? w_data[gi*8 +: 8] : div_reg[gi*8 +: 8];
  end
  // A divisor of zero would stall the bit timer, so it is promoted to one.
  assign div_next = (div_merged == 16'd0) ? 16'd1 : div_merged;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push_ok;
  logic          push_drop;
  state_t        state_reg;

  assign full      = (count_reg == CW'(FIFO_DEPTH));
  assign empty     = (count_reg == '0);
  assign pop       = (state_reg == ST_IDLE) && enable_reg && !empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still fits.
  assign push_ok   = push_req && (!full || pop);
  assign push_drop = push_req && full && !pop;

  // Software-visible configuration and the sticky overflow flag.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      div_reg    <= 16'(DEFAULT_DIV);
      enable_reg <= 1'b1;
      irq_en_reg <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      if (div_wr) begin
        div_reg <= div_next;
      end
      if (ctrl_wr) begin
        enable_reg <= w_data[0];
        irq_en_reg <= w_data[1];
      end
      if (ovf_clr) begin
        ovf_reg <= 1'b0;
      end
      if (push_drop) begin
        ovf_reg <= 1'b1;
      end
    end
  end

  // FIFO storage: plain write port, no reset so it can map onto RAM.
  always_ff @(posedge sysclk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_reg] <= w_data[7:0];
    end
  end

  // FIFO pointers and occupancy; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------- serialiser
  logic [15:0] timer_reg;
  logic [15:0] div_lat_reg;
  logic [2:0]  bit_idx_reg;
  logic [7:0]  shift_reg;
  logic        tx_reg;

  // Frame FSM; tx_reg follows the state of the previous cycle so the line is glitch-free.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      timer_reg   <= 16'd0;
      div_lat_reg <= 16'd1;
      bit_idx_reg <= 3'd0;
      shift_reg   <= 8'd0;
      tx_reg      <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          tx_reg <= 1'b1;
          if (pop) begin
            shift_reg   <= fifo_mem[rd_ptr_reg];
            timer_reg   <= div_reg;
            div_lat_reg <= div_reg;
            bit_idx_reg <= 3'd0;
            state_reg   <= ST_START;
          end
        end
        ST_START: begin
          tx_reg <= 1'b0;
          if (timer_reg == 16'd1) begin
            timer_reg <= div_lat_reg;
            state_reg <= ST_DATA;
          end else begin
            timer_reg <= timer_reg - 16'd1;
          end
        end
        ST_DATA: begin
          tx_reg <= shift_reg[0];
          if (timer_reg == 16'd1) begin
            timer_reg <= div_lat_reg;
            shift_reg <= {1'b0, shift_reg[7:1]};
            if (bit_idx_reg == 3'd7) begin
              state_reg <= ST_STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
            end
          end else begin
            timer_reg <= timer_reg - 16'd1;
          end
        end
        ST_STOP: begin
          tx_reg <= 1'b1;
          if (timer_reg == 16'd1) begin
            state_reg <= ST_IDLE;
          end else begin
            timer_reg <= timer_reg - 16'd1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          tx_reg    <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- interrupt
  logic irq_reg;

  // Level interrupt: transmitter fully drained and idle, sampled one edge late.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      irq_reg <= 1'b0;
    end else begin
      irq_reg <= irq_en_reg && empty && (state_reg == ST_IDLE);
    end
  end

  // ---------------------------------------------------------------- read port
  logic [31:0] status_word;
  logic [31:0] rd_val;
  logic [31:0] r_data_reg;

  // STATUS and register read mux.
  always_comb begin
    status_word          = 32'd0;
    status_word[0]       = (state_reg != ST_IDLE);
    status_word[1]       = full;
    status_word[2]       = empty;
    status_word[3]       = ovf_reg;
    status_word[8 +: CW] = count_reg;
    rd_val               = 32'd0;
    case (reg_sel)
      2'd1:    rd_val = status_word;
      2'd2:    rd_val = {16'd0, div_reg};
      2'd3:    rd_val = {30'd0, irq_en_reg, enable_reg};
      default: rd_val = 32'd0;
    endcase
  end

  // Registered read data with the same one-cycle latency as data memory; holds when idle.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      r_data_reg <= 32'd0;
    end else if (r_en) begin
      r_data_reg <= in_range ? rd_val : 32'd0;
    end
  end

  assign r_data = r_data_reg;
  assign tx     = tx_reg;
  assign irq    = irq_reg;

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the CPU data-store path, downstream of the CPU next to data memory.
- Decodes the word address and byte write enables that the data memory also receives.
- Buffers written bytes in a small FIFO and serialises them 8N1 on a tx pin.
- Exposes status, baud divisor and control registers readable with the same one-cycle latency as data memory.

Parameters:
- ADDR_WIDTH, 12, width of the word address input.
- BASE_ADDR, 12'hF00, word address of register 0; registers occupy BASE_ADDR..BASE_ADDR+3.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, at least 2.
- DEFAULT_DIV, 868, reset value of BAUDDIV (sysclk cycles per bit).

Ports:
- sysclk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- addr  in  ADDR_WIDTH  word address (same as data memory address).
- w_data  in  32  store data.
- byte_w_en  in  4  byte write enables; all-zero means no write.
- r_en  in  1  read strobe.
- r_data  out  32  registered read data.
- tx  out  1  serial output, idle high.
- irq  out  1  level interrupt.

Behaviour:
- Reset (rst=1 at an edge): tx=1, r_data=0, irq=0, FIFO empty, FSM=IDLE.
- Register reset values: BAUDDIV=DEFAULT_DIV, CTRL.enable=1, CTRL.irq_en=0, overflow=0.
- Reset mid-frame abandons the frame; tx is 1 after that edge.
- Register map, as word offsets from BASE_ADDR:
  - 0 TXDATA: write with byte_w_en[0]=1 pushes w_data[7:0]; reads return 0.
  - 1 STATUS (read): bit0 busy (FSM!=IDLE), bit1 full, bit2 empty, bit3 overflow, bits[8+:CW] FIFO count with CW=$clog2(FIFO_DEPTH)+1, other bits 0.
  - 1 STATUS (write): writing 1 to bit3 with byte_w_en[0] clears overflow; other bits ignored.
  - 2 BAUDDIV: bits[15:0], byte-lane writable (lanes 0,1); a written value of 0 is stored as 1; upper bits read 0.
  - 3 CTRL: bit0 enable, bit1 irq_en; byte lane 0 writable.
- Writes outside BASE_ADDR..BASE_ADDR+3 are ignored.
- Reads: r_data updates the edge after r_en=1. In-range address gives the register value; out-of-range gives 0. With r_en=0, r_data holds.
- Push when FIFO is full: byte dropped, overflow set (sticky).
- Push and pop in the same cycle: both happen. Full plus pop plus push is accepted; count is unchanged.
- A push to an empty FIFO cannot pop in the same cycle.
- FSM:
  - IDLE: tx=1. If enable=1 and FIFO not empty, pop the head into the shift register, latch BAUDDIV into the bit timer, go to START.
  - START: tx=0 for DIV cycles, then DATA.
  - DATA: 8 bits LSB first, each held DIV cycles, then STOP.
  - STOP: tx=1 for DIV cycles, then IDLE.
- Frame length from the first tx=0 cycle is exactly 10*DIV cycles. Back-to-back frames have exactly 1 extra idle-high cycle (the IDLE pop cycle) between them.
- BAUDDIV writes mid-frame affect only the next frame.
- Clearing enable mid-frame lets the current frame complete; no new pops occur.
- tx is driven from a register (glitch-free).
- irq is registered: irq = irq_en & empty & ~busy, evaluated one edge late.

Test Plan:
- Reset with BAUDDIV set to 4; write 8'hA5 to TXDATA -> tx low 4 cycles starting 2 cycles after the write edge, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop high 4 cycles; total 40 cycles; STATUS.busy=1 during the frame.
- Write 3 bytes 8'h01,8'h02,8'h03 back-to-back with DIV=4 -> three frames, each separated by exactly 1 idle-high cycle; STATUS count reads 2 immediately after the third write; empty=1 after the last frame.
- Fill the FIFO with 9 writes while enable=0 -> full=1, count=8, overflow=1, 9th byte absent; then write STATUS 32'h8 -> overflow=0; set enable=1 -> 8 frames in order.
- Set irq_en=1, transmit one byte -> irq=0 during the frame, irq=1 within 1 cycle of STOP completion; a new write drops irq the next edge.
- Assert rst for 1 cycle mid-DATA -> tx=1 next edge, STATUS reads 32'h4, BAUDDIV reads 868, no residual frame.
- Read address BASE_ADDR+5 -> r_data=0; write BAUDDIV=0 -> reads back 1, and a frame lasts 10 cycles.
